uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. The divisor, parity and stop-bit settings are
// captured when a word is popped, so they stay fixed for the whole frame.
module uart_tx_fifo #(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_FIFO_DEPTH = 16,
    parameter int p_DIV_WIDTH  = 16
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [p_DATA_WIDTH-1:0]            iv_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [p_DIV_WIDTH-1:0]             iv_divisor,
    input  logic                               i_parity_en,
    input  logic                               i_parity_odd,
    input  logic                               i_two_stop,
    output logic                               o_tx,
    output logic                               o_busy,
    output logic                               o_frame_done,
    output logic [$clog2(p_FIFO_DEPTH+1)-1:0]  ov_level
);
    localparam int AW = $clog2(p_FIFO_DEPTH);
    localparam int LW = $clog2(p_FIFO_DEPTH + 1);
    localparam int BW = $clog2(p_DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(p_DATA_WIDTH - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(p_FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [p_DATA_WIDTH-1:0] mem [p_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic                    push, pop, empty, bit_end, frame_done, tx;
    logic [p_DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [p_DIV_WIDTH-1:0]  baud_cnt_q, div_q;
    logic                    par_en_q, par_bit_q, two_stop_q, stop_cnt_q;

    assign empty   = (level_q == '0);
    assign o_ready = (level_q != FULL_LEVEL);
    assign push    = i_valid && o_ready;
    assign bit_end = (baud_cnt_q == '0);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        tx         = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                tx = par_bit_q;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Last stop period: chain straight into the next frame when data is waiting.
                if (bit_end && stop_cnt_q == two_stop_q) begin
                    frame_done = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: the storage array has no reset; a flush only clears pointers and level.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= iv_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                shift_q    <= mem[rd_ptr_q];
                div_q      <= iv_divisor;
                baud_cnt_q <= iv_divisor;
                par_en_q   <= i_parity_en;
                par_bit_q  <= (^mem[rd_ptr_q]) ^ i_parity_odd;
                two_stop_q <= i_two_stop;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (state_q != IDLE) begin
                if (!bit_end) begin
                    baud_cnt_q <= baud_cnt_q - p_DIV_WIDTH'(1);
                end else begin
                    baud_cnt_q <= div_q;
                    if (state_q == DATA) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                    if (state_q == STOP) stop_cnt_q <= 1'b1;
                end
            end
        end
    end

    assign o_tx         = tx;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = frame_done;
    assign ov_level     = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-vector table, directed corner sequences and random
// traffic, all compared every cycle against a transaction-level model.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic [15:0] div;
    logic        pen, podd, two;
    logic        ready, tx, busy, done;
    logic [4:0]  level;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .iv_data      (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .iv_divisor   (div),
        .i_parity_en  (pen),
        .i_parity_odd (podd),
        .i_two_stop   (two),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_frame_done (done),
        .ov_level     (level)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pen;
        bit         podd;
        bit         two;
        int         exp_len;
        bit         exp_par;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_times [$];

    // Reference model: a queue of words plus the frame currently on the wire.
    logic [7:0] m_q [$];
    logic [7:0] m_word;
    int         m_remain = 0;
    int         m_len = 0;
    int         m_div = 0;
    bit         m_pe, m_po;

    int         n, len, per, bad, bad2, t1, prob;
    logic [7:0] rx;
    logic       wave [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int frame_len(input int d, input bit pe, input bit ts);
        return (1 + DW + (pe ? 1 : 0) + (ts ? 2 : 1)) * (d + 1);
    endfunction

    function automatic logic frame_bit(input logic [7:0] w, input int idx, input bit pe, input bit po);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[idx-1];
        if (pe && idx == DW + 1) return (^w) ^ po;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int sz;
        bit do_pop, do_push;
        if (rst) begin
            m_q.delete();
            m_remain = 0;
            return;
        end
        sz      = m_q.size();
        do_pop  = (sz > 0) && (m_remain <= 1);
        do_push = valid && (sz != DEPTH);
        if (do_pop) begin
            m_word   = m_q.pop_front();
            m_div    = int'(div);
            m_pe     = pen;
            m_po     = podd;
            m_len    = frame_len(m_div, pen, two);
            m_remain = m_len;
        end else if (m_remain > 0) begin
            m_remain--;
        end
        if (do_push) m_q.push_back(data);
    endtask

    task automatic step();
        logic exp_tx;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        if (m_remain == 0) exp_tx = 1'b1;
        else exp_tx = frame_bit(m_word, (m_len - m_remain) / (m_div + 1), m_pe, m_po);
        check("model_tx",    tx,    exp_tx);
        check("model_busy",  busy,  m_remain > 0);
        check("model_done",  done,  m_remain == 1);
        check("model_level", level, m_q.size());
        check("model_ready", ready, m_q.size() != DEPTH);
        if (done === 1'b1) done_times.push_back(cyc);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 40, 1'b0};
        vecs[1] = '{8'h07, 0, 1'b1, 1'b0, 1'b0, 11, 1'b1};
        vecs[2] = '{8'h07, 0, 1'b1, 1'b1, 1'b0, 11, 1'b0};
        vecs[3] = '{8'h07, 0, 1'b1, 1'b0, 1'b1, 12, 1'b1};
        vecs[4] = '{8'h00, 1, 1'b1, 1'b1, 1'b1, 24, 1'b1};
        vecs[5] = '{8'hFF, 2, 1'b1, 1'b0, 1'b0, 33, 1'b0};
        vecs[6] = '{8'h3C, 0, 1'b0, 1'b0, 1'b1, 11, 1'b0};

        data = '0; valid = 1'b0; div = '0; pen = 1'b0; podd = 1'b0; two = 1'b0; rst = 1'b1;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_level", level, 0);
        check("rst_ready", ready, 1);

        // Reset wins over a write in the same cycle.
        data = 8'h11; valid = 1'b1;
        step();
        check("rst_override_level", level, 0);
        rst = 1'b0; valid = 1'b0;
        step();
        check("rst_override_idle", level, 0);

        // Single frames from the vector table, decoded from the sampled line.
        for (int k = 0; k < 7; k++) begin
            div = 16'(vecs[k].div); pen = vecs[k].pen; podd = vecs[k].podd; two = vecs[k].two;
            data = vecs[k].data; valid = 1'b1;
            step();
            valid = 1'b0;
            check("lat_e0_tx", tx, 1);
            check("lat_e0_level", level, 1);
            step();
            check("lat_e1_tx", tx, 0);
            len = 1;
            wave[0] = tx;
            while (done !== 1'b1 && len < 1000) begin
                step();
                wave[len] = tx;
                len++;
            end
            check("frame_len", len, vecs[k].exp_len);
            per = vecs[k].div + 1;
            for (int i = 0; i < DW; i++) rx[i] = wave[(1 + i) * per];
            check("rx_data", rx, vecs[k].data);
            if (vecs[k].pen) check("parity_bit", wave[(DW + 1) * per], vecs[k].exp_par);
            bad = 0;
            bad2 = 0;
            for (int c = 0; c < len; c++) begin
                if (wave[c] !== wave[(c / per) * per]) bad++;
                if (c >= (DW + 1 + (vecs[k].pen ? 1 : 0)) * per && wave[c] !== 1'b1) bad2++;
            end
            check("bit_period_stable", bad, 0);
            check("stop_high", bad2, 0);
            step();
            check("idle_after_frame", busy, 0);
        end

        // Fill the FIFO behind a slow frame; the 17th word must wait for the first pop.
        done_times.delete();
        div = 16'd200; pen = 1'b0; two = 1'b0; data = 8'h5A; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check("stall_started", tx, 0);
        div = 16'd1;
        for (int i = 0; i < 16; i++) begin
            data = 8'(i * 13 + 7); valid = 1'b1;
            step();
            check("fill_level", level, i + 1);
        end
        check("full_ready", ready, 0);
        data = 8'hEE; valid = 1'b1;
        n = 0; bad = 0;
        while (done !== 1'b1 && n < 2100) begin
            step();
            n++;
            if (level !== 5'd16) bad++;
        end
        check("held_full", bad, 0);
        check("stall_wait", n, 1993);
        step();
        check("after_pop_level", level, 15);
        check("after_pop_ready", ready, 1);
        step();
        check("word17_accepted", level, 16);
        valid = 1'b0;
        repeat (17 * 20) step();
        check("frames_done", done_times.size(), 18);
        for (int i = 1; i < done_times.size(); i++)
            check("back_to_back_gap", done_times[i] - done_times[i-1], 20);
        step();
        check("drained_busy", busy, 0);

        // Configuration change mid-frame applies only to the next frame.
        done_times.delete();
        div = 16'd2; pen = 1'b0; two = 1'b0;
        data = 8'hC3; valid = 1'b1;
        step();
        data = 8'h3C;
        step();
        t1 = cyc;
        valid = 1'b0;
        repeat (10) step();
        div = 16'd0; pen = 1'b1; podd = 1'b0;
        n = 0;
        while (done_times.size() < 2 && n < 200) begin
            step();
            n++;
        end
        check("mid_cfg_frames", done_times.size(), 2);
        if (done_times.size() >= 2) begin
            check("mid_cfg_first_len", done_times[0] - t1, 29);
            check("mid_cfg_second_len", done_times[1] - done_times[0], 11);
        end
        repeat (3) step();
        pen = 1'b0;

        // Reset in the middle of DATA with five words queued.
        div = 16'd3;
        for (int i = 0; i < 6; i++) begin
            data = 8'(8'h80 + i); valid = 1'b1;
            step();
        end
        check("queued5_level", level, 5);
        check("queued5_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; valid = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || level !== 5'd0) bad++;
        end
        check("no_frames_after_reset", bad, 0);

        // Write and pop on the same edge at level 3.
        div = 16'd0;
        for (int i = 0; i < 4; i++) begin
            data = 8'((i + 1) * 17); valid = 1'b1;
            step();
        end
        valid = 1'b0;
        check("lvl3", level, 3);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("lvl3_done_seen", done, 1);
        check("lvl3_at_done", level, 3);
        data = 8'h99; valid = 1'b1;
        step();
        valid = 1'b0;
        check("write_pop_same_edge", level, 3);
        n = 0;
        while ((busy !== 1'b0 || level !== 5'd0) && n < 500) begin
            step();
            n++;
        end
        check("lvl3_drained", busy, 0);

        // Random traffic with occasional mid-frame configuration changes.
        for (int r = 0; r < 8; r++) begin
            div  = 16'($urandom_range(0, 3));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            two  = 1'($urandom_range(0, 1));
            prob = $urandom_range(20, 95);
            repeat (300) begin
                valid = ($urandom_range(0, 99) < prob);
                data  = 8'($urandom);
                if ($urandom_range(0, 99) == 0) div = 16'($urandom_range(0, 3));
                step();
            end
            valid = 1'b0;
        end
        n = 0;
        while ((busy !== 1'b0 || level !== 5'd0) && n < 5000) begin
            step();
            n++;
        end
        check("random_drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
